// File: rtl/switch_ingress_shaper_pkg.sv
// Shared packet format, field widths and FSM encoding for the switch ingress shaper.
package switch_ingress_shaper_pkg;

    localparam int NUM_PORTS = 4;
    localparam int SRC_W     = 4;
    localparam int TGT_W     = 4;
    localparam int DATA_W    = 8;

    typedef struct packed {
        logic [SRC_W-1:0]  src;
        logic [TGT_W-1:0]  tgt;
        logic [DATA_W-1:0] data;
    } pkt_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        GAP   = 2'd2
    } shp_state_t;

    // A packet is illegal if it has no destination or targets the port it enters on.
    function automatic logic is_illegal(input logic [TGT_W-1:0] tgt, input int port_id);
        return (tgt == '0) || tgt[port_id[1:0]];
    endfunction

endpackage

// File: rtl/switch_ingress_shaper_ingress_fifo.sv
// Synchronous packet FIFO with registered full/empty flags; pointers wrap modulo DEPTH.
module ingress_fifo
    import switch_ingress_shaper_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic push,
    input  logic pop,
    input  pkt_t din,
    output pkt_t dout,
    output logic full,
    output logic empty
);

    localparam int AW = $clog2(DEPTH);

    pkt_t          mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic [AW:0]   count_next;
    logic          do_push;
    logic          do_pop;

    // A push into a full buffer is only taken when a pop frees the slot on the same edge.
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign dout    = mem[rd_ptr];

    always_comb begin
        count_next = count;
        if (do_push && !do_pop) begin
            count_next = count + (AW+1)'(1);
        end else if (!do_push && do_pop) begin
            count_next = count - (AW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            full   <= 1'b0;
            empty  <= 1'b1;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            count <= count_next;
            full  <= (count_next == (AW+1)'(DEPTH));
            empty <= (count_next == '0);
        end
    end

endmodule

// File: rtl/switch_ingress_shaper.sv
// Ingress shaper: filters illegal packets, buffers legal ones and feeds one switch port
// with single-cycle strobes spaced so the switch's registered full flag is always current.
module switch_ingress_shaper
    import switch_ingress_shaper_pkg::*;
#(
    parameter int PORT_ID    = 0,
    parameter int DEPTH      = 4,
    parameter int GAP_CYCLES = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        src_valid,
    output logic        src_ready,
    input  logic [3:0]  src_source,
    input  logic [3:0]  src_target,
    input  logic [7:0]  src_data,
    output logic        sw_valid_in,
    output logic [3:0]  sw_source_in,
    output logic [3:0]  sw_target_in,
    output logic [7:0]  sw_data_in,
    input  logic        sw_fifo_full,
    output logic [15:0] pkt_sent_cnt,
    output logic [15:0] pkt_reject_cnt
);

    shp_state_t state;
    shp_state_t state_next;
    logic [3:0] gap_cnt;
    logic       buf_full;
    logic       buf_empty;
    pkt_t       head;
    pkt_t       in_pkt;
    logic       accept;
    logic       illegal;
    logic       push;
    logic       pop;
    logic       sent_inc;

    // Source handshake: a packet transfers on any rising edge where src_valid && src_ready;
    // src_ready depends only on registered buffer state, never on src_valid.
    assign src_ready = !buf_full;
    assign accept    = src_valid && src_ready;
    assign illegal   = is_illegal(src_target, PORT_ID);
    assign push      = accept && !illegal;
    assign in_pkt    = '{src: src_source, tgt: src_target, data: src_data};

    ingress_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .din   (in_pkt),
        .dout  (head),
        .full  (buf_full),
        .empty (buf_empty)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        unique case (state)
            IDLE:    if (!buf_empty && !sw_fifo_full) state_next = ISSUE;
            ISSUE:   state_next = (GAP_CYCLES > 0) ? GAP : IDLE;
            GAP:     if (gap_cnt == 4'(GAP_CYCLES - 1)) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        pop      = (state == IDLE) && !buf_empty && !sw_fifo_full;
        sent_inc = (state == ISSUE);
    end

    always_ff @(posedge clk) begin
        if (rst || state != GAP) begin
            gap_cnt <= '0;
        end else begin
            gap_cnt <= gap_cnt + 4'd1;
        end
    end

    // Switch-side fields are only reloaded on an issue so they hold between strobes.
    always_ff @(posedge clk) begin
        if (rst) begin
            sw_valid_in    <= 1'b0;
            sw_source_in   <= '0;
            sw_target_in   <= '0;
            sw_data_in     <= '0;
            pkt_sent_cnt   <= '0;
            pkt_reject_cnt <= '0;
        end else begin
            sw_valid_in <= pop;
            if (pop) begin
                sw_source_in <= head.src;
                sw_target_in <= head.tgt;
                sw_data_in   <= head.data;
            end
            if (sent_inc && pkt_sent_cnt != 16'hFFFF) begin
                pkt_sent_cnt <= pkt_sent_cnt + 16'd1;
            end
            if (accept && illegal && pkt_reject_cnt != 16'hFFFF) begin
                pkt_reject_cnt <= pkt_reject_cnt + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_switch_ingress_shaper.sv
// Self-checking bench for switch_ingress_shaper: table of packets plus hand-written corner sequences.
module tb_switch_ingress_shaper;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        src_valid;
    logic [3:0]  src_source;
    logic [3:0]  src_target;
    logic [7:0]  src_data;
    logic        sw_fifo_full;

    logic        src_ready;
    logic        sw_valid_in;
    logic [3:0]  sw_source_in;
    logic [3:0]  sw_target_in;
    logic [7:0]  sw_data_in;
    logic [15:0] pkt_sent_cnt;
    logic [15:0] pkt_reject_cnt;

    logic        g_ready;
    logic        g_valid;
    logic [3:0]  g_src;
    logic [3:0]  g_tgt;
    logic [7:0]  g_data;
    logic [15:0] g_sent;
    logic [15:0] g_rej;

    switch_ingress_shaper #(.PORT_ID(0), .DEPTH(4), .GAP_CYCLES(0)) dut (
        .clk            (clk),
        .rst            (rst),
        .src_valid      (src_valid),
        .src_ready      (src_ready),
        .src_source     (src_source),
        .src_target     (src_target),
        .src_data       (src_data),
        .sw_valid_in    (sw_valid_in),
        .sw_source_in   (sw_source_in),
        .sw_target_in   (sw_target_in),
        .sw_data_in     (sw_data_in),
        .sw_fifo_full   (sw_fifo_full),
        .pkt_sent_cnt   (pkt_sent_cnt),
        .pkt_reject_cnt (pkt_reject_cnt)
    );

    switch_ingress_shaper #(.PORT_ID(0), .DEPTH(4), .GAP_CYCLES(2)) dut_gap (
        .clk            (clk),
        .rst            (rst),
        .src_valid      (src_valid),
        .src_ready      (g_ready),
        .src_source     (src_source),
        .src_target     (src_target),
        .src_data       (src_data),
        .sw_valid_in    (g_valid),
        .sw_source_in   (g_src),
        .sw_target_in   (g_tgt),
        .sw_data_in     (g_data),
        .sw_fifo_full   (sw_fifo_full),
        .pkt_sent_cnt   (g_sent),
        .pkt_reject_cnt (g_rej)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] src;
        logic [3:0] tgt;
        logic [7:0] data;
        logic       exp_reject;
    } vec_t;

    vec_t        vecs [7];
    int          tests = 0;
    int          fails = 0;
    int          cyc = 0;
    int          pulse_cnt = 0;
    int          pulse_cyc [$];
    logic [15:0] exp_q [$];
    int          g_cyc [$];
    logic [15:0] g_pkt [$];
    int          last_hs_cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Scoreboard for the GAP_CYCLES=0 instance: every strobe must match the queue head.
    always @(negedge clk) begin
        if (!rst && sw_valid_in) begin
            pulse_cnt++;
            pulse_cyc.push_back(cyc);
            if (exp_q.size() == 0) begin
                check("unexpected_issue", {16'h0, sw_source_in, sw_target_in, sw_data_in}, 32'hFFFF_FFFF);
            end else begin
                check("issue_pkt", {16'h0, sw_source_in, sw_target_in, sw_data_in}, {16'h0, exp_q.pop_front()});
            end
        end
    end

    always @(negedge clk) begin
        if (!rst && g_valid) begin
            g_cyc.push_back(cyc);
            g_pkt.push_back({g_src, g_tgt, g_data});
        end
    end

    // Called at a falling edge; returns at the falling edge after the handshake edge.
    task automatic send(input logic [3:0] s, input logic [3:0] t, input logic [7:0] d, input logic legal);
        int w = 0;
        src_valid  = 1'b1;
        src_source = s;
        src_target = t;
        src_data   = d;
        while (!src_ready && w < 200) begin
            @(negedge clk);
            w++;
        end
        if (!src_ready) begin
            check("send_ready_timeout", {31'h0, src_ready}, 32'h1);
            src_valid = 1'b0;
        end else begin
            if (legal) exp_q.push_back({s, t, d});
            @(posedge clk);
            @(negedge clk);
            src_valid   = 1'b0;
            last_hs_cyc = cyc;
        end
    endtask

    task automatic drain();
        int w = 0;
        while (exp_q.size() != 0 && w < 300) begin
            @(negedge clk);
            w++;
        end
        check("drain_queue", exp_q.size(), 0);
        repeat (3) @(negedge clk);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        int hs;
        int base;
        int rej0;
        int pc0;

        vecs[0] = '{4'h2, 4'b0000, 8'h11, 1'b1};
        vecs[1] = '{4'h3, 4'b0001, 8'h22, 1'b1};
        vecs[2] = '{4'h4, 4'b0110, 8'h33, 1'b0};
        vecs[3] = '{4'h5, 4'b1111, 8'h44, 1'b1};
        vecs[4] = '{4'h6, 4'b1110, 8'h55, 1'b0};
        vecs[5] = '{4'h7, 4'b1000, 8'h66, 1'b0};
        vecs[6] = '{4'h8, 4'b0011, 8'h77, 1'b1};

        src_valid    = 1'b0;
        src_source   = '0;
        src_target   = '0;
        src_data     = '0;
        sw_fifo_full = 1'b0;
        rst          = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_src_ready", {31'h0, src_ready}, 32'h1);
        check("rst_sw_valid", {31'h0, sw_valid_in}, 32'h0);
        check("rst_sw_fields", {16'h0, sw_source_in, sw_target_in, sw_data_in}, 32'h0);
        check("rst_sent_cnt", pkt_sent_cnt, 32'h0);
        check("rst_reject_cnt", pkt_reject_cnt, 32'h0);
        check("rst_gap_ready", {31'h0, g_ready}, 32'h1);
        rst = 1'b0;
        @(negedge clk);

        // Single packet: latency, one-cycle strobe, held fields, sent count.
        send(4'h1, 4'b0110, 8'hA5, 1'b1);
        hs = last_hs_cyc;
        drain();
        check("t1_pulses", pulse_cnt, 1);
        check("t1_latency", (pulse_cyc.size() > 0) ? pulse_cyc[0] : -1, hs + 1);
        check("t1_sent_cnt", pkt_sent_cnt, 1);
        check("t1_valid_low", {31'h0, sw_valid_in}, 32'h0);
        check("t1_hold_fields", {24'h0, sw_target_in, 4'h0}, {24'h0, 4'b0110, 4'h0});
        check("t1_hold_data", {24'h0, sw_data_in}, 32'hA5);

        foreach (vecs[i]) begin
            rej0 = pkt_reject_cnt;
            send(vecs[i].src, vecs[i].tgt, vecs[i].data, !vecs[i].exp_reject);
            check("vec_reject_cnt", pkt_reject_cnt, rej0 + int'(vecs[i].exp_reject));
        end
        drain();
        check("table_sent_cnt", pkt_sent_cnt, 4);
        check("table_pulses", pulse_cnt, 4);

        // Switch full: buffer fills, source is back-pressured, then drains at one per 2 cycles.
        sw_fifo_full = 1'b1;
        for (int k = 0; k < 4; k++) send(4'h9, 4'b0010 << (k % 3), 8'hB0 + 8'(k), 1'b1);
        check("t3_ready_low", {31'h0, src_ready}, 32'h0);
        repeat (4) @(negedge clk);
        check("t3_no_issue", pulse_cnt, 4);
        base = pulse_cyc.size();
        sw_fifo_full = 1'b0;
        send(4'hA, 4'b1100, 8'hB4, 1'b1);
        drain();
        check("t3_pulses", pulse_cnt, 9);
        for (int k = 1; k < 5; k++) check("t3_period", pulse_cyc[base+k] - pulse_cyc[base+k-1], 2);
        check("t3_sent_cnt", pkt_sent_cnt, 9);

        // Continuous stream: buffer takes pushes while popping; order and no rejects.
        rej0 = pkt_reject_cnt;
        base = pulse_cyc.size();
        for (int k = 0; k < 8; k++) begin
            send(4'(k), 4'($urandom_range(1, 7) << 1), 8'($urandom_range(0, 255)), 1'b1);
        end
        drain();
        check("t6_pulses", pulse_cnt, 17);
        check("t6_sent_cnt", pkt_sent_cnt, 17);
        check("t6_reject_cnt", pkt_reject_cnt, rej0);
        for (int k = 1; k < 8; k++) check("t6_period", pulse_cyc[base+k] - pulse_cyc[base+k-1], 2);

        // Reset with packets buffered: nothing may ever be issued afterwards.
        sw_fifo_full = 1'b1;
        for (int k = 0; k < 3; k++) send(4'hC, 4'b0100, 8'hC0 + 8'(k), 1'b1);
        rst = 1'b1;
        @(negedge clk);
        exp_q.delete();
        check("t5_valid", {31'h0, sw_valid_in}, 32'h0);
        check("t5_ready", {31'h0, src_ready}, 32'h1);
        check("t5_fields", {16'h0, sw_source_in, sw_target_in, sw_data_in}, 32'h0);
        check("t5_sent_cnt", pkt_sent_cnt, 0);
        check("t5_reject_cnt", pkt_reject_cnt, 0);
        rst = 1'b0;
        sw_fifo_full = 1'b0;
        pc0 = pulse_cnt;
        repeat (20) @(negedge clk);
        check("t5_no_issue", pulse_cnt, pc0);
        check("t5_sent_after", pkt_sent_cnt, 0);

        // GAP_CYCLES=2 instance: back-to-back packets issue exactly 4 cycles apart.
        g_cyc.delete();
        g_pkt.delete();
        send(4'hD, 4'b0010, 8'hD1, 1'b1);
        send(4'hD, 4'b0100, 8'hD2, 1'b1);
        send(4'hD, 4'b1000, 8'hD3, 1'b1);
        drain();
        repeat (12) @(negedge clk);
        check("t4_gap_pulses", g_cyc.size(), 3);
        if (g_cyc.size() == 3) begin
            check("t4_gap_period0", g_cyc[1] - g_cyc[0], 4);
            check("t4_gap_period1", g_cyc[2] - g_cyc[1], 4);
            check("t4_gap_pkt0", {16'h0, g_pkt[0]}, 32'hD2D1);
            check("t4_gap_pkt1", {16'h0, g_pkt[1]}, 32'hD4D2);
            check("t4_gap_pkt2", {16'h0, g_pkt[2]}, 32'hD8D3);
        end
        check("t4_gap_sent", g_sent, 3);
        check("t4_gap_reject", g_rej, 0);
        check("t4_sent_cnt", pkt_sent_cnt, 3);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
